register_slice_sync_rstn: RTL
=============================

// Module: register_slice_sync_rstn
// PURPOSE
//  Parametrised valid/ready register slice: the handshaked successor of the plain sync-reset register.
//  Chains STAGES identical stages to break timing paths on a streaming interface without losing throughput.
//  MODE picks which paths are registered: forward-only, full (forward + backpressure), or bypass.
//  Sits between any two valid/ready producers/consumers in SVLib-based datapaths.
// PARAMETERS
//  WIDTH      32   payload width in bits (>=1)
//  STAGES     1    number of chained slice stages (>=1; ignored when MODE=BYPASS)
//  MODE       FULL slice_mode_e: BYPASS, FORWARD or FULL
//  RESET_VAL  '0   value of every stage data register (and m_data) during/after reset
// PORTS
//  clk      in   1      clock; all state updates on posedge
//  rstn     in   1      synchronous active-low reset
//  s_valid  in   1      upstream data valid
//  s_ready  out  1      slice accepts s_data this cycle
//  s_data   in   WIDTH  upstream payload
//  m_valid  out  1      downstream data valid
//  m_ready  in   1      downstream accepts m_data this cycle
//  m_data   out  WIDTH  downstream payload
// BEHAVIOUR
//  - Transfer on an edge where valid&&ready (both sides). No beat lost, duplicated or reordered.
//  - Reset (rstn=0 sampled at posedge): all stages empty; m_valid=0, m_data=RESET_VAL; FULL: s_ready=0.
//    Reset mid-stream discards all held beats; no partial beat appears after release.
//  - BYPASS: m_valid=s_valid, m_data=s_data, s_ready=m_ready combinationally; no state; rstn unused.
//  - FORWARD stage: one entry. s_ready = ~m_valid | m_ready (combinational from m_ready).
//    Load on s_valid&&s_ready; m_valid clears when m_ready && !load. Latency 1 cycle/stage, 1 beat/cycle.
//  - FULL stage: 2-entry skid buffer, both directions registered (no comb path s->m or m->s).
//    States: EMPTY (0 held), ONE (main reg valid), TWO (main + skid valid).
//    EMPTY: in -> ONE.   ONE: in&!out -> TWO; out&!in -> EMPTY; in&out -> ONE (main reloads).
//    TWO: out -> ONE (skid moves to main); no in accepted (s_ready=0).
//    s_ready is a flop: 1 in EMPTY/ONE, 0 in TWO; 0 during reset, 1 the first cycle after release.
//    m_valid = state!=EMPTY; m_data = main reg. Latency 1 cycle/stage; sustains 1 beat/cycle with m_ready=1.
//  - Chain: stage k's m side drives stage k+1's s side. Total latency = STAGES cycles on an idle pipe.
//    Capacity: FORWARD = STAGES beats, FULL = 2*STAGES beats.
//  - Simultaneous in+out at full occupancy: FORWARD accepts (ready via m_ready); FULL does not (registered ready).
//  - Data registers load only on accept (no toggling when idle); data in empty stages is don't-care
//    but must not be visible while m_valid=0 except RESET_VAL after reset.
//  - Elaboration error if WIDTH<1 or STAGES<1.
// STRUCTURE
//  - Package svlib_regslice_pkg: typedef enum {BYPASS, FORWARD, FULL} slice_mode_e;
//    typedef enum logic[1:0] {SKID_EMPTY, SKID_ONE, SKID_TWO} skid_state_e.
//  - Sub-module slice_stage_sync_rstn (WIDTH, MODE, RESET_VAL): one FORWARD or FULL stage.
//  - Top: generate loop instantiating STAGES stages, or wire-through for BYPASS.
// TESTING (run for MODE in {FORWARD, FULL}, STAGES in {1,3}, WIDTH=8; BYPASS smoke test)
//  1 Reset: rstn=0 2 cycles, s_valid=1 -> m_valid=0, m_data=RESET_VAL; FULL s_ready=0 then 1 one cycle after release.
//  2 Streaming: send 0x00..0x3F back-to-back, m_ready=1 -> all 64 out in order, first after STAGES cycles, 1/cycle.
//  3 Backpressure: m_ready=0, s_valid=1 -> accepts exactly STAGES (FWD) or 2*STAGES (FULL) beats, then s_ready=0; release -> in-order drain.
//  4 Random valid/ready (50%/50%, 10k beats, scoreboard) -> no loss/dup/reorder; FULL: s_ready never depends on m_ready same cycle.
//  5 Reset mid-stream with 3 beats held -> next cycle m_valid=0; post-release stream 0xA0.. emerges with no stale beat.
//  6 BYPASS: s_data=0x5A, s_valid=1, m_ready=0 -> m_valid=1, m_data=0x5A, s_ready=0 same cycle.

Source files
------------

// File: rtl/svlib_regslice_pkg.sv
// Shared types for the valid/ready register slice: slice mode selection and skid-buffer states.
package svlib_regslice_pkg;

  typedef enum logic [1:0] {BYPASS, FORWARD, FULL} slice_mode_e;

  typedef enum logic [1:0] {SKID_EMPTY, SKID_ONE, SKID_TWO} skid_state_e;

endpackage

// File: rtl/slice_stage_sync_rstn.sv
// One valid/ready slice stage: a single-entry forward register or a two-entry fully registered skid buffer.
module slice_stage_sync_rstn
  import svlib_regslice_pkg::*;
#(
  parameter int                WIDTH     = 32,
  parameter slice_mode_e       MODE      = FULL,
  parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data
);

  if (MODE == FORWARD) begin : g_fwd
    logic             valid_q;
    logic [WIDTH-1:0] data_q;
    logic             load;

    assign s_ready = ~valid_q | m_ready;
    assign load    = s_valid & s_ready;

    always_ff @(posedge clk) begin
      if (!rstn) begin
        valid_q <= 1'b0;
        data_q  <= RESET_VAL;
      end else if (load) begin
        valid_q <= 1'b1;
        data_q  <= s_data;
      end else if (m_ready) begin
        valid_q <= 1'b0;
      end
    end

    assign m_valid = valid_q;
    assign m_data  = data_q;
  end else begin : g_full
    skid_state_e      state;
    logic             ready_q;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] skid_q;
    logic             take;

    assign take = s_valid & ready_q;

    // ready_q is the registered form of "next state is not TWO", so s_ready never sees m_ready combinationally.
    always_ff @(posedge clk) begin
      if (!rstn) begin
        state   <= SKID_EMPTY;
        ready_q <= 1'b0;
        main_q  <= RESET_VAL;
        skid_q  <= RESET_VAL;
      end else begin
        case (state)
          SKID_EMPTY: begin
            ready_q <= 1'b1;
            if (take) begin
              main_q <= s_data;
              state  <= SKID_ONE;
            end
          end
          SKID_ONE: begin
            if (take && !m_ready) begin
              skid_q  <= s_data;
              state   <= SKID_TWO;
              ready_q <= 1'b0;
            end else if (take) begin
              main_q  <= s_data;
              ready_q <= 1'b1;
            end else if (m_ready) begin
              state   <= SKID_EMPTY;
              ready_q <= 1'b1;
            end else begin
              ready_q <= 1'b1;
            end
          end
          SKID_TWO: begin
            if (m_ready) begin
              main_q  <= skid_q;
              state   <= SKID_ONE;
              ready_q <= 1'b1;
            end
          end
          default: begin
            state   <= SKID_EMPTY;
            ready_q <= 1'b1;
          end
        endcase
      end
    end

    assign s_ready = ready_q;
    assign m_valid = (state != SKID_EMPTY);
    assign m_data  = main_q;
  end

endmodule

// File: rtl/register_slice_sync_rstn.sv
// Parametrised valid/ready register slice: STAGES chained slice stages, or a plain wire-through in BYPASS.
module register_slice_sync_rstn
  import svlib_regslice_pkg::*;
#(
  parameter int                WIDTH     = 32,
  parameter int                STAGES    = 1,
  parameter slice_mode_e       MODE      = FULL,
  parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data
);

  if (WIDTH < 1) begin : g_bad_width
    $error("register_slice_sync_rstn: WIDTH must be >= 1");
  end
  if (STAGES < 1) begin : g_bad_stages
    $error("register_slice_sync_rstn: STAGES must be >= 1");
  end

  if (MODE == BYPASS) begin : g_bypass
    logic unused_clk_rstn;
    assign unused_clk_rstn = &{1'b0, clk, rstn};

    assign m_valid = s_valid;
    assign m_data  = s_data;
    assign s_ready = m_ready;
  end else begin : g_chain
    logic             valid [STAGES+1];
    logic             ready [STAGES+1];
    logic [WIDTH-1:0] data  [STAGES+1];

    assign valid[0]      = s_valid;
    assign data[0]       = s_data;
    assign s_ready       = ready[0];
    assign ready[STAGES] = m_ready;
    assign m_valid       = valid[STAGES];
    assign m_data        = data[STAGES];

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
      slice_stage_sync_rstn #(
        .WIDTH     (WIDTH),
        .MODE      (MODE),
        .RESET_VAL (RESET_VAL)
      ) u_stage (
        .clk     (clk),
        .rstn    (rstn),
        .s_valid (valid[k]),
        .s_ready (ready[k]),
        .s_data  (data[k]),
        .m_valid (valid[k+1]),
        .m_ready (ready[k+1]),
        .m_data  (data[k+1])
      );
    end
  end

endmodule
